// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants for the register file with pending-writer scoreboard.
package mcu_rf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Read ports, two writeback ports, issue port and scoreboard status.
interface reg_file_scoreboard_if
  import mcu_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);
  logic [NUM_RD*ADDR_W-1:0] RA;
  logic [NUM_RD*DATA_W-1:0] RD;
  logic [NUM_RD-1:0]        RD_BUSY;
  logic                     WE0;
  logic [ADDR_W-1:0]        WA0;
  logic [DATA_W-1:0]        WD0;
  logic                     WE1;
  logic [ADDR_W-1:0]        WA1;
  logic [DATA_W-1:0]        WD1;
  logic                     ISSUE_EN;
  logic [ADDR_W-1:0]        ISSUE_A;
  logic [ADDR_W:0]          BUSY_CNT;

  modport master (
    output RA, WE0, WA0, WD0, WE1, WA1, WD1, ISSUE_EN, ISSUE_A,
    input  RD, RD_BUSY, BUSY_CNT
  );

  modport slave (
    input  RA, WE0, WA0, WD0, WE1, WA1, WD1, ISSUE_EN, ISSUE_A,
    output RD, RD_BUSY, BUSY_CNT
  );
endinterface

// File: rtl/reg_file_scoreboard_sb.sv
// Pending bits per register, running pending count and per-read-port hazard flags.
module rf_scoreboard
  import mcu_rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     i_we0,
  input  logic [ADDR_W-1:0]        i_wa0,
  input  logic                     i_we1,
  input  logic [ADDR_W-1:0]        i_wa1,
  input  logic                     i_issue_en,
  input  logic [ADDR_W-1:0]        i_issue_a,
  input  logic [NUM_RD*ADDR_W-1:0] i_ra,
  output logic [NUM_RD-1:0]        o_rd_busy,
  output logic [ADDR_W:0]          o_busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] w_pend;
  logic             w_wr0_ok, w_wr1_ok, w_iss_ok;
  logic             w_inc, w_dec0, w_dec1;
  logic [CNT_W-1:0] r_busy_cnt;

  assign w_wr0_ok = i_we0 && (i_wa0 != ZERO_A);
  assign w_wr1_ok = i_we1 && (i_wa1 != ZERO_A);
  assign w_iss_ok = i_issue_en && (i_issue_a != ZERO_A);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pend
      if (gi == ZERO_REG) begin : g_zero
        assign w_pend[gi] = 1'b0;
      end else begin : g_bit
        logic r_p;
        // Issue beats writeback: a new producer keeps the register pending.
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) begin
            r_p <= 1'b0;
          end else if (w_iss_ok && (i_issue_a == ADDR_W'(gi))) begin
            r_p <= 1'b1;
          end else if ((w_wr0_ok && (i_wa0 == ADDR_W'(gi))) ||
                       (w_wr1_ok && (i_wa1 == ADDR_W'(gi)))) begin
            r_p <= 1'b0;
          end
        end
        assign w_pend[gi] = r_p;
      end
    end
  endgenerate

  // Count deltas; two writes to one register retire it only once.
  assign w_inc  = w_iss_ok && !w_pend[i_issue_a];
  assign w_dec0 = w_wr0_ok && w_pend[i_wa0] && !(w_iss_ok && (i_issue_a == i_wa0));
  assign w_dec1 = w_wr1_ok && w_pend[i_wa1] && !(w_iss_ok && (i_issue_a == i_wa1))
                  && !(w_wr0_ok && (i_wa0 == i_wa1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt + CNT_W'(w_inc) - CNT_W'(w_dec0) - CNT_W'(w_dec1);
    end
  end
  assign o_busy_cnt = r_busy_cnt;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_haz
      logic [ADDR_W-1:0] w_ra;
      assign w_ra = i_ra[gi*ADDR_W +: ADDR_W];
      assign o_rd_busy[gi] = w_pend[w_ra]
                             && !(w_wr0_ok && (i_wa0 == w_ra))
                             && !(w_wr1_ok && (i_wa1 == w_ra));
    end
  endgenerate
endmodule

// File: rtl/reg_file_scoreboard.sv
// Flip-flop register file with two writeback ports, write bypass on reads and a pending scoreboard.
module reg_file_scoreboard
  import mcu_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                 CLK,
  input  logic                 RESET,
  reg_file_scoreboard_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]        w_regs [DEPTH];
  logic [NUM_RD*DATA_W-1:0] w_rd;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_ff
        logic [DATA_W-1:0] r_reg;
        // Port 1 (load) is checked first so it wins a same-address collision.
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) begin
            r_reg <= '0;
          end else if (bus.WE1 && (bus.WA1 == ADDR_W'(gi))) begin
            r_reg <= bus.WD1;
          end else if (bus.WE0 && (bus.WA0 == ADDR_W'(gi))) begin
            r_reg <= bus.WD0;
          end
        end
        assign w_regs[gi] = r_reg;
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_hit0, w_hit1;
      assign w_ra   = bus.RA[gi*ADDR_W +: ADDR_W];
      // Writes presented during reset are dropped, so they must not bypass either.
      assign w_hit1 = !RESET && bus.WE1 && (bus.WA1 == w_ra) && (w_ra != ZERO_A);
      assign w_hit0 = !RESET && bus.WE0 && (bus.WA0 == w_ra) && (w_ra != ZERO_A);
      assign w_rd[gi*DATA_W +: DATA_W] = w_hit1 ? bus.WD1 :
                                         w_hit0 ? bus.WD0 : w_regs[w_ra];
    end
  endgenerate

  assign bus.RD = w_rd;

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_we0      (bus.WE0),
    .i_wa0      (bus.WA0),
    .i_we1      (bus.WE1),
    .i_wa1      (bus.WA1),
    .i_issue_en (bus.ISSUE_EN),
    .i_issue_a  (bus.ISSUE_A),
    .i_ra       (bus.RA),
    .o_rd_busy  (bus.RD_BUSY),
    .o_busy_cnt (bus.BUSY_CNT)
  );
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Randomized + directed bench: stimulus pushes predictions, a monitor pops and compares.
module tb_reg_file_scoreboard;
  import mcu_rf_pkg::*;
  localparam int DW    = DEF_DATA_W;
  localparam int AW    = DEF_ADDR_W;
  localparam int NR    = DEF_NUM_RD;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus();

  reg_file_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    string            tag;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    busy;
    logic [AW:0]      cnt;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  // Architectural model: register values and the set of registers awaiting a writer.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic exp_t predict(input string tag);
    exp_t e;
    int   n;
    e.tag  = tag;
    e.rd   = '0;
    e.busy = '0;
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
    e.cnt = rst ? '0 : (AW+1)'(n);
    if (!rst) begin
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] a;
        logic          w0, w1;
        a  = bus.RA[k*AW +: AW];
        w0 = bus.WE0 && (bus.WA0 == a) && (a != 0);
        w1 = bus.WE1 && (bus.WA1 == a) && (a != 0);
        if (a == 0)  e.rd[k*DW +: DW] = '0;
        else if (w1) e.rd[k*DW +: DW] = bus.WD1;
        else if (w0) e.rd[k*DW +: DW] = bus.WD0;
        else         e.rd[k*DW +: DW] = m_mem[a];
        e.busy[k] = m_pend[a] && !w0 && !w1;
      end
    end
    return e;
  endfunction

  task automatic step(input string tag, input logic r,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic e0, input logic [AW-1:0] w0, input logic [DW-1:0] d0,
                      input logic e1, input logic [AW-1:0] w1, input logic [DW-1:0] d1,
                      input logic ie, input logic [AW-1:0] ia);
    @(negedge clk);
    rst          = r;
    bus.RA       = {a1, a0};
    bus.WE0      = e0;
    bus.WA0      = w0;
    bus.WD0      = d0;
    bus.WE1      = e1;
    bus.WA1      = w1;
    bus.WD1      = d1;
    bus.ISSUE_EN = ie;
    bus.ISSUE_A  = ia;
    #2;
    if (r) model_clear();
    exp_q.push_back(predict(tag));
    ->sample_ev;
    @(posedge clk);
    if (!r) begin
      if (e0 && w0 != 0) begin m_mem[w0] = d0; m_pend[w0] = 1'b0; end
      if (e1 && w1 != 0) begin m_mem[w1] = d1; m_pend[w1] = 1'b0; end
      if (ie && ia != 0) m_pend[ia] = 1'b1;
    end
  endtask

  task automatic idle(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    step(tag, 1'b0, a0, a1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h", tag, what, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        chk("monitor", "queue_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("%0t %s ra=%h rd=%h busy=%b cnt=%0d", $time, e.tag, bus.RA, bus.RD,
                 bus.RD_BUSY, bus.BUSY_CNT);
        chk(e.tag, "rd",   64'(bus.RD),       64'(e.rd));
        chk(e.tag, "busy", 64'(bus.RD_BUSY),  64'(e.busy));
        chk(e.tag, "cnt",  64'(bus.BUSY_CNT), 64'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.RA = '0; bus.WE0 = 0; bus.WA0 = '0; bus.WD0 = '0;
    bus.WE1 = 0; bus.WA1 = '0; bus.WD1 = '0; bus.ISSUE_EN = 0; bus.ISSUE_A = '0;
    model_clear();
    #1 rst = 1'b1;

    for (int a = 0; a < DEPTH; a++)
      step("rst_read", 1'b1, AW'(a), AW'(DEPTH-1-a), 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    step("rst_discard", 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h5678, 1'b1, 5'd4);

    step("bypass", 1'b0, 5'd3, 5'd4, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
    idle("persist", 5'd3, 5'd4);

    step("collide", 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, '0);
    idle("collide_after", 5'd5, 5'd0);

    step("issue7", 1'b0, 5'd7, 5'd0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
    idle("busy7", 5'd7, 5'd7);
    step("wb7", 1'b0, 5'd7, 5'd1, 1'b0, '0, '0, 1'b1, 5'd7, 32'hA7, 1'b0, '0);
    idle("clear7", 5'd7, 5'd1);

    step("issue9", 1'b0, 5'd9, 5'd0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    step("iss_wb9", 1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b1, 5'd9);
    idle("still9", 5'd9, 5'd0);
    step("r0_ops", 1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE, 1'b1, 5'd0);
    idle("r0_after", 5'd0, 5'd9);
    step("reissue9", 1'b0, 5'd9, 5'd0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    step("wb9", 1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h999, 1'b0, '0, '0, 1'b0, '0);

    for (int i = 1; i <= 4; i++)
      step("fill", 1'b0, AW'(i), 5'd0, 1'b1, AW'(i), DW'(32'hC0 + i), 1'b0, '0, '0, 1'b1, AW'(i));
    idle("filled", 5'd1, 5'd4);
    step("mid_rst", 1'b1, 5'd1, 5'd4, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd6);
    step("post_rst", 1'b0, 5'd2, 5'd6, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd2);
    idle("count1", 5'd2, 5'd1);

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a0, a1, w0, w1, ia;
      logic          e0, e1, ie, r;
      int            lim;
      lim = ($urandom_range(0, 3) == 0) ? DEPTH-1 : 7;
      a0 = AW'($urandom_range(0, lim)); a1 = AW'($urandom_range(0, lim));
      w0 = AW'($urandom_range(0, lim)); w1 = AW'($urandom_range(0, lim));
      ia = AW'($urandom_range(0, lim));
      e0 = 1'($urandom_range(0, 1)); e1 = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 99) == 0);
      step("rand", r, a0, a1, e0, w0, DW'($urandom), e1, w1, DW'($urandom), ie, ia);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) chk("end", "queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 RA  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 RD  output  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
REQ-008 RD_BUSY  output  NUM_RD  per-port hazard flag: the read value is not yet final.
REQ-009 WE0, WA0, WD0  input  1/ADDR_W/DATA_W  write port 0 (ALU writeback).
REQ-010 WE1, WA1, WD1  input  1/ADDR_W/DATA_W  write port 1 (load writeback).
REQ-011 ISSUE_EN, ISSUE_A  input  1/ADDR_W  marks destination register ISSUE_A as pending.
REQ-012 BUSY_CNT  output  ADDR_W+1  number of registers currently pending.

Function
REQ-013 Register 0 SHALL read 0, ignore writes, and never become pending.
REQ-014 Writes SHALL commit on the rising CLK edge when WEx=1 and WAx!=0.
REQ-015 When WE0 and WE1 target the same address in one cycle, WD1 SHALL win.
REQ-016 Reads SHALL be combinational, with same-cycle write bypass: if RA[k] matches an enabled write address, RD[k] returns that write data (WD1 before WD0); otherwise it returns the stored value.
REQ-017 Pending bit p[r] SHALL be set on the edge when ISSUE_EN=1 and ISSUE_A=r (r!=0).
REQ-018 p[r] SHALL be cleared on the edge when any enabled write targets r and no issue targets r in the same cycle.
REQ-019 If issue and writeback target the same r in one cycle, p[r] SHALL remain/become 1 (the new producer wins).
REQ-020 RD_BUSY[k] SHALL be p[RA[k]] AND NOT (a same-cycle enabled write to RA[k]); it SHALL be 0 for RA[k]=0.
REQ-021 BUSY_CNT SHALL be a registered count kept equal to popcount(p) after every edge; increments and decrements in the same cycle SHALL net correctly (range 0..2**ADDR_W-1).
REQ-022 An issue to an already-pending register SHALL leave p and BUSY_CNT unchanged.
REQ-023 A write to a non-pending register SHALL update data and leave p and BUSY_CNT unchanged.
REQ-024 Read latency SHALL be 0 cycles; write-to-storage latency 1 edge; issue-to-RD_BUSY latency 1 edge.

Reset
REQ-025 While RESET=1, all registers, all p bits and BUSY_CNT SHALL be 0 immediately, regardless of CLK.
REQ-026 Writes or issues presented on an edge while RESET=1 SHALL be discarded.
REQ-027 The first edge after RESET deasserts SHALL behave as a normal operating edge.

Structure
REQ-028 Package mcu_rf_pkg SHALL hold the default DATA_W/ADDR_W/NUM_RD constants and the ZERO_REG index constant.
REQ-029 Sub-module rf_scoreboard (p bits, BUSY_CNT, hazard logic) SHALL be separated from the data array and bypass muxes.
REQ-030 Storage SHALL be flip-flops (no RAM macro), allowing asynchronous reset.

Verification
REQ-031 Reset: hold RESET=1, read all addresses -> RD=0, RD_BUSY=0, BUSY_CNT=0.
REQ-032 Bypass: WE0=1, WA0=3, WD0=0xDEADBEEF, RA[0]=3 in the same cycle -> RD[0]=0xDEADBEEF before the edge, and the value persists after it.
REQ-033 Collision: WE0/WE1 both to r5 with 0x11/0x22 -> r5=0x22 after the edge.
REQ-034 Scoreboard: issue r7 -> next cycle RD_BUSY=1 for RA=7, BUSY_CNT=1; write r7 -> RD_BUSY=0 in that cycle, BUSY_CNT=0 after the edge.
REQ-035 Same-cycle issue and writeback to r9 (r9 pending) -> p[9] stays 1, BUSY_CNT unchanged; r0 issue/write -> no effect.
REQ-036 Mid-operation reset: r1..r4 pending with data written, assert RESET between edges -> all outputs 0 immediately, and the next issue counts from BUSY_CNT=1.
